// File: rtl/mem_init_pkg.sv
// Shared types and constants for the memory-initialisation sequencer.
package mem_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_DLY,
        ST_RUN
    } state_e;

    // Word index sits above the 2-bit byte offset in MEM_ADDR.
    localparam int BYTE_OFF = 2;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_init_dly_cnt.sv
// Release-delay down-counter: load arms it, zero_o flags expiry, skip_o
// reports a zero-length delay so the caller can bypass the wait state.
module mem_init_dly_cnt #(
    parameter int DLY = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o,
    output logic skip_o
);

    localparam int CW     = (DLY > 1) ? $clog2(DLY) : 1;
    localparam int DLY_M1 = (DLY > 0) ? DLY - 1 : 0;

    logic [CW-1:0] cnt_q, cnt_d;

    // Loaded with DLY-1 so the waiting state lasts exactly DLY cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = CW'(DLY_M1);
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign skip_o = (DLY == 0);
    assign zero_o = skip_o || (cnt_q == '0);

endmodule

// File: rtl/mem_init_seq.sv
// Streams words into N_CH memories in turn, then releases the core reset.
// Define MEM_INIT_ZERO_FILL_EN to zero-fill the tail of a channel closed by LAST.
module mem_init_seq
    import mem_init_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int RELEASE_DLY = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              LOAD_VALID,
    output logic              LOAD_READY,
    input  logic [DATA_W-1:0] LOAD_DATA,
    input  logic              LOAD_LAST,
    output logic [N_CH-1:0]   MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA,
    output logic [N_CH-1:0]   CH_DONE,
    output logic              ERR,
    output logic              CORE_RSTn
);

    localparam int IDX_W = idx_w(DEPTH);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(N_CH - 1);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ready_q, ready_d;
    logic [N_CH-1:0]   we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [N_CH-1:0]   done_q, done_d;
    logic              err_q, err_d;
    logic              rstn_q, rstn_d;

    logic acc, at_end, close, ovf, fill_wr;
    logic cnt_load, cnt_en, cnt_zero, cnt_skip;

    assign acc    = LOAD_VALID && ready_q && (state_q == ST_LOAD);
    assign at_end = (idx_q == IDX_MAX);
    assign cnt_en = (state_q == ST_DLY);

`ifdef MEM_INIT_ZERO_FILL_EN
    assign fill_wr = (state_q == ST_FILL);
`else
    assign fill_wr = 1'b0;
`endif

    mem_init_dly_cnt #(.DLY(RELEASE_DLY)) u_dly (
        .clk_i  (CLK),
        .rst_i  (RST),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .zero_o (cnt_zero),
        .skip_o (cnt_skip)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rstn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rstn_q  <= rstn_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        idx_d    = idx_q;
        close    = 1'b0;
        ovf      = 1'b0;
        cnt_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_LOAD;
                    ch_d    = '0;
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                if (acc) begin
                    idx_d = idx_q + 1'b1;
                    // Running off the end without LAST: the next word starts the next channel.
                    if (!LOAD_LAST && at_end) begin
                        ovf   = 1'b1;
                        close = 1'b1;
                    end
`ifdef MEM_INIT_ZERO_FILL_EN
                    else if (LOAD_LAST && !at_end)
                        state_d = ST_FILL;
`endif
                    else if (LOAD_LAST)
                        close = 1'b1;
                end
            end
`ifdef MEM_INIT_ZERO_FILL_EN
            ST_FILL: begin
                idx_d = idx_q + 1'b1;
                if (at_end)
                    close = 1'b1;
            end
`endif
            ST_DLY: begin
                if (cnt_zero)
                    state_d = ST_RUN;
            end
            ST_RUN: state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase

        if (close) begin
            if (ch_q != CH_MAX) begin
                ch_d    = ch_q + 1'b1;
                idx_d   = '0;
                state_d = ST_LOAD;
            end else if (cnt_skip) begin
                state_d = ST_RUN;
            end else begin
                state_d  = ST_DLY;
                cnt_load = 1'b1;
            end
        end
    end

    always_comb begin
        ready_d = (state_d == ST_LOAD);
        rstn_d  = (state_d == ST_RUN);
        err_d   = err_q | ovf;
        we_d    = '0;
        done_d  = done_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (acc || fill_wr) begin
            addr_d = '0;
            addr_d[BYTE_OFF +: IDX_W] = idx_q;
            data_d = fill_wr ? '0 : LOAD_DATA;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                we_d[i] = acc || fill_wr;
                if (close)
                    done_d[i] = 1'b1;
            end
        end
    end

    assign LOAD_READY = ready_q;
    assign MEM_WE     = we_q;
    assign MEM_ADDR   = addr_q;
    assign MEM_DATA   = data_q;
    assign CH_DONE    = done_q;
    assign ERR        = err_q;
    assign CORE_RSTn  = rstn_q;

endmodule

// File: tb/tb_mem_init_seq.sv
// Bench for mem_init_seq: three parameterisations share one stimulus bus;
// sel picks which instance the write scoreboard and checks look at.
module tb_mem_init_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        VALID = 1'b0;
    logic        LAST = 1'b0;
    logic [31:0] DATA = '0;

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // u0: defaults; u1: DEPTH=4 for overflow; u2: N_CH=1, DEPTH=8, no delay
    logic        r0, e0, n0, r1, e1, n1, r2, e2, n2;
    logic [1:0]  we0, dn0, we1, dn1;
    logic [0:0]  we2, dn2;
    logic [31:0] a0, d0, a1, d1, a2, d2;

    mem_init_seq u0 (
        .CLK(CLK), .RST(RST), .START(START), .LOAD_VALID(VALID), .LOAD_READY(r0),
        .LOAD_DATA(DATA), .LOAD_LAST(LAST), .MEM_WE(we0), .MEM_ADDR(a0), .MEM_DATA(d0),
        .CH_DONE(dn0), .ERR(e0), .CORE_RSTn(n0));

    mem_init_seq #(.N_CH(2), .DEPTH(4), .RELEASE_DLY(4)) u1 (
        .CLK(CLK), .RST(RST), .START(START), .LOAD_VALID(VALID), .LOAD_READY(r1),
        .LOAD_DATA(DATA), .LOAD_LAST(LAST), .MEM_WE(we1), .MEM_ADDR(a1), .MEM_DATA(d1),
        .CH_DONE(dn1), .ERR(e1), .CORE_RSTn(n1));

    mem_init_seq #(.N_CH(1), .DEPTH(8), .RELEASE_DLY(0)) u2 (
        .CLK(CLK), .RST(RST), .START(START), .LOAD_VALID(VALID), .LOAD_READY(r2),
        .LOAD_DATA(DATA), .LOAD_LAST(LAST), .MEM_WE(we2), .MEM_ADDR(a2), .MEM_DATA(d2),
        .CH_DONE(dn2), .ERR(e2), .CORE_RSTn(n2));

    int          sel = 0;
    logic        cur_ready, cur_err, cur_rstn;
    logic [1:0]  cur_we, cur_done;
    logic [31:0] cur_addr, cur_data;

    always_comb begin
        cur_ready = r0; cur_err = e0; cur_rstn = n0;
        cur_we = we0; cur_done = dn0; cur_addr = a0; cur_data = d0;
        if (sel == 1) begin
            cur_ready = r1; cur_err = e1; cur_rstn = n1;
            cur_we = we1; cur_done = dn1; cur_addr = a1; cur_data = d1;
        end else if (sel == 2) begin
            cur_ready = r2; cur_err = e2; cur_rstn = n2;
            cur_we = {1'b0, we2}; cur_done = {1'b0, dn2}; cur_addr = a2; cur_data = d2;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          ch;
        logic [31:0] addr;
        logic [1:0]  done;
        logic        err;
    } vec_t;

    wr_t sb[$];
    int  wr_cnt = 0;
    int  wr_first = 0;
    int  wr_last = 0;

    always @(negedge CLK) begin : mon
        wr_t e;
        if (cur_we != 2'b00) begin
            wr_cnt++;
            if (wr_cnt == 1) wr_first = cyc;
            wr_last = cyc;
            if (sb.size() == 0) begin
                chk("unexpected write", 32'(cur_we), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("write strobe", 32'(cur_we), 32'(e.we));
                chk("write addr", cur_addr, e.addr);
                chk("write data", cur_data, e.data);
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic expect_wr(input int ch, input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        e.we = (ch == 1) ? 2'b10 : 2'b01;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        while (!cur_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cur_ready) begin
            chk("ready timeout", 32'(cur_ready), 32'h1);
            return;
        end
        VALID = 1'b1;
        DATA = v.data;
        LAST = v.last;
        expect_wr(v.ch, v.addr, v.data);
        tick();
    endtask

    task automatic idle();
        VALID = 1'b0;
        LAST = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        RST = 1'b1; START = 1'b0; VALID = 1'b0; LAST = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        sb.delete();
        wr_cnt = 0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t tv_main[5];
    vec_t tv_ovf[5];
    vec_t tv_tog[4];
    int   hs;

    initial begin
        tv_main[0] = '{32'hA, 1'b0, 0, 32'h0, 2'b00, 1'b0};
        tv_main[1] = '{32'hB, 1'b0, 0, 32'h4, 2'b00, 1'b0};
        tv_main[2] = '{32'hC, 1'b1, 0, 32'h8, 2'b01, 1'b0};
        tv_main[3] = '{32'h1, 1'b0, 1, 32'h0, 2'b01, 1'b0};
        tv_main[4] = '{32'h2, 1'b1, 1, 32'h4, 2'b11, 1'b0};

        tv_ovf[0] = '{32'h10, 1'b0, 0, 32'h0, 2'b00, 1'b0};
        tv_ovf[1] = '{32'h11, 1'b0, 0, 32'h4, 2'b00, 1'b0};
        tv_ovf[2] = '{32'h12, 1'b0, 0, 32'h8, 2'b00, 1'b0};
        tv_ovf[3] = '{32'h13, 1'b0, 0, 32'hC, 2'b01, 1'b1};
        tv_ovf[4] = '{32'h14, 1'b0, 1, 32'h0, 2'b01, 1'b1};

        for (int i = 0; i < 4; i++)
            tv_tog[i] = '{32'h20 + 32'(i), 1'b0, 0, 32'(4 * i), 2'b00, 1'b0};

        // reset state
        sel = 0;
        do_reset();
        chk("reset ready", 32'(cur_ready), 32'h0);
        chk("reset we", 32'(cur_we), 32'h0);
        chk("reset addr", cur_addr, 32'h0);
        chk("reset data", cur_data, 32'h0);
        chk("reset done", 32'(cur_done), 32'h0);
        chk("reset err", 32'(cur_err), 32'h0);
        chk("reset rstn", 32'(cur_rstn), 32'h0);

`ifndef MEM_INIT_ZERO_FILL_EN
        // two channels, back-to-back, then the 4-cycle release delay
        pulse_start();
        chk("ready after start", 32'(cur_ready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            send(tv_main[i]);
            chk("main done", 32'(cur_done), 32'(tv_main[i].done));
            chk("main err", 32'(cur_err), 32'(tv_main[i].err));
        end
        hs = cyc;
        idle();
        chk("main ready after final", 32'(cur_ready), 32'h0);
        chk("main write count", 32'(wr_cnt), 32'd5);
        chk("main writes consecutive", 32'(wr_last - wr_first), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("main rstn held low", 32'(cur_rstn), 32'h0);
            tick();
        end
        chk("main rstn release cycle", 32'(cyc - hs), 32'd4);
        chk("main rstn released", 32'(cur_rstn), 32'h1);
        chk("main sb empty", 32'(sb.size()), 32'h0);
`endif

        // overflow at DEPTH=4, spill into ch1, then reset mid-load
        sel = 1;
        do_reset();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            send(tv_ovf[i]);
            chk("ovf done", 32'(cur_done), 32'(tv_ovf[i].done));
            chk("ovf err", 32'(cur_err), 32'(tv_ovf[i].err));
        end
        idle();
        chk("ovf sb empty", 32'(sb.size()), 32'h0);
        RST = 1'b1;
        tick();
        chk("midrst done", 32'(cur_done), 32'h0);
        chk("midrst err", 32'(cur_err), 32'h0);
        chk("midrst rstn", 32'(cur_rstn), 32'h0);
        chk("midrst ready", 32'(cur_ready), 32'h0);
        RST = 1'b0;
        tick();
        pulse_start();
        chk("restart ready", 32'(cur_ready), 32'h1);
        send('{32'h55, 1'b0, 0, 32'h0, 2'b00, 1'b0});
        idle();
        tick();
        chk("restart sb empty", 32'(sb.size()), 32'h0);

        // VALID toggling 1,0,1,0: no missed or extra writes, no address gaps
        sel = 0;
        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send(tv_tog[i]);
            idle();
            tick();
        end
        chk("toggle write count", 32'(wr_cnt), 32'd4);
        chk("toggle sb empty", 32'(sb.size()), 32'h0);

        // single channel, zero release delay
        sel = 2;
        do_reset();
        pulse_start();
`ifdef MEM_INIT_ZERO_FILL_EN
        send('{32'hA1, 1'b0, 0, 32'h0, 2'b00, 1'b0});
        send('{32'hA2, 1'b1, 0, 32'h4, 2'b00, 1'b0});
        hs = cyc;
        idle();
        for (int k = 2; k < 8; k++)
            expect_wr(0, 32'(4 * k), 32'h0);
        chk("fill done not yet", 32'(cur_done), 32'h0);
        for (int k = 1; k < 6; k++) begin
            tick();
            chk("fill ready low", 32'(cur_ready), 32'h0);
            chk("fill done low", 32'(cur_done), 32'h0);
        end
        tick();
        chk("fill done set", 32'(cur_done), 32'h1);
        chk("fill rstn", 32'(cur_rstn), 32'h1);
        chk("fill last write cycle", 32'(wr_last - hs), 32'd6);
        chk("fill sb empty", 32'(sb.size()), 32'h0);
`else
        send('{32'h77, 1'b1, 0, 32'h0, 2'b01, 1'b0});
        idle();
        chk("nodly rstn", 32'(cur_rstn), 32'h1);
        chk("nodly done", 32'(cur_done), 32'h1);
        chk("nodly ready", 32'(cur_ready), 32'h0);
`endif
        // START and VALID while in RUN must do nothing
        pulse_start();
        VALID = 1'b1;
        DATA = 32'h99;
        tick();
        tick();
        tick();
        idle();
        tick();
        chk("run rstn held", 32'(cur_rstn), 32'h1);
        chk("run ready low", 32'(cur_ready), 32'h0);
        chk("run err clear", 32'(cur_err), 32'h0);
        chk("run sb empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_init_seq.md
# mem_init_seq

Parametrised memory-initialisation sequencer for the RISC-V simulation top. It accepts a valid/ready word stream and writes it sequentially into N_CH memories: channel 0 is instruction memory, channel 1 is data memory, and further channels are extra banks. It raises a per-channel done flag as each channel completes. Once every channel is done, it releases an active-low core reset after a programmable delay. It replaces the fixed two-input AND of memory-ready flags with a loader that has counting, bounds checking and delayed release.

## Interface
- N_CH, 2, number of memory channels (≥1)
- DATA_W, 32, data word width
- ADDR_W, 32, byte-address width of MEM_ADDR
- DEPTH, 1024, words per channel (power of two, ≤ 2^(ADDR_W-2))
- RELEASE_DLY, 4, cycles from all-done to CORE_RSTn rising (0 allowed)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  one-cycle pulse that begins loading; honoured only in IDLE
- LOAD_VALID  in  1  stream word valid
- LOAD_READY  out  1  sequencer accepts a word
- LOAD_DATA  in  DATA_W  stream word
- LOAD_LAST  in  1  marks the final word of the current channel
- MEM_WE  out  N_CH  one-hot write strobe
- MEM_ADDR  out  ADDR_W  byte address, {word_idx, 2'b00}, zero-extended
- MEM_DATA  out  DATA_W  write data
- CH_DONE  out  N_CH  sticky, channel complete
- ERR  out  1  sticky, a channel overflowed DEPTH
- CORE_RSTn  out  1  active-low reset to the core

## Operation
- States:
  - IDLE: wait for START.
  - LOAD: accept stream words.
  - FILL: zero-fill; exists only when the macro is defined.
  - DLY: count the release delay.
  - RUN: terminal state.
- IDLE→LOAD on START. ch=0, idx=0.
- LOAD behaviour:
  - LOAD_READY=1 in LOAD only; it is registered and combinationally independent of LOAD_VALID.
  - A word is accepted when LOAD_VALID & LOAD_READY. The accepted word is written to channel ch at idx, then idx increments.
- A channel closes when either:
  - an accepted word has LOAD_LAST=1, or
  - an accepted word lands at idx=DEPTH-1 with LOAD_LAST=0. This is overflow: set ERR, close the channel, and treat subsequent stream words as belonging to the next channel.
- On close:
  - CH_DONE[ch] is set.
  - If ch<N_CH-1, then ch increments and idx resets to 0.
  - Otherwise the state goes to DLY.
- LAST together with idx=DEPTH-1 is a normal close, and ERR is not set.
- DLY loads a counter with RELEASE_DLY and decrements it. The state moves to RUN when the counter is 0. With RELEASE_DLY=0, DLY lasts zero cycles and the state goes straight to RUN.
- RUN: CORE_RSTn=1. START is ignored. The block stays in RUN until RST.
- START outside IDLE is ignored. LOAD_VALID outside LOAD is ignored, with no write and no error.
- RST at any time, including mid-load: state returns to IDLE and all outputs return to their reset values on the next edge. Partially written memory contents are not cleared.
- Reset values: LOAD_READY=0, MEM_WE=0, MEM_ADDR=0, MEM_DATA=0, CH_DONE=0, ERR=0, CORE_RSTn=0.

## Timing
- START at edge t: state is LOAD and LOAD_READY=1 from t+1.
- Handshake at edge c: MEM_WE/MEM_ADDR/MEM_DATA are valid for exactly one cycle at c+1. Write latency is 1, and back-to-back writes are allowed at one per cycle.
- Closing handshake at c: CH_DONE[ch]=1 at c+1.
- For the final channel:
  - LOAD_READY=0 at c+1.
  - CORE_RSTn=1 at c+1+RELEASE_DLY.
  - This assumes no fill. When fill is enabled, count from the last fill write.
- All outputs are registered.

## Configuration
- MEM_INIT_ZERO_FILL_EN defined:
  - A LAST-close at idx<DEPTH-1 enters FILL.
  - FILL writes 0 to idx+1 … DEPTH-1, one word per cycle, with LOAD_READY=0.
  - CH_DONE is set after the final fill write, and the state then advances as on a normal close.
  - Overflow closes never fill.
- Undefined: the FILL state and its logic are absent, and a channel closes immediately on LAST.

## Structure
- Package mem_init_pkg holds:
  - the state enum (IDLE, LOAD, FILL, DLY, RUN);
  - the IDX_W=$clog2(DEPTH) helper;
  - the byte-offset constant (2).
- The sub-module mem_init_dly_cnt holds the parametrised down-counter with load, zero flag and RELEASE_DLY=0 bypass. It is instantiated once.

## Test plan
- Defaults, ch0 gets 3 words (0xA, 0xB, 0xC with LAST), ch1 gets 2 words (0x1, 0x2 with LAST), VALID held high:
  - Writes go to ch0 addr 0/4/8, then ch1 addr 0/4, on consecutive cycles.
  - CH_DONE goes 01 then 11.
  - CORE_RSTn rises 5 cycles after the final handshake.
- DEPTH=4, ch0 gets 5 words without LAST:
  - ERR=1 after the 4th word at addr 0xC.
  - The 5th word goes to ch1 addr 0.
- RST asserted mid-load on ch1:
  - Next cycle shows IDLE, CH_DONE=0, ERR=0, CORE_RSTn=0.
  - A new START reloads from ch0 addr 0.
- LOAD_VALID toggled 1,0,1,0 on alternate cycles: exactly one write per accepted word, and addresses have no gaps.
- RELEASE_DLY=0, N_CH=1, a single word with LAST: CORE_RSTn=1 one cycle after the handshake. A START pulse in RUN has no effect.
- MEM_INIT_ZERO_FILL_EN, DEPTH=8, 2 words then LAST:
  - Zeros are written to addr 0x8–0x1C.
  - LOAD_READY=0 during the fill.
  - CH_DONE[0] is set after the 0x1C write.
